// File: rtl/integer_wb.sv
// integer_wb: writeback stage for the integer unit.
// Tracks the instruction issued last cycle, writes its selected result into
// the integer register file one cycle later, keeps the CF/OF/ZF flag
// registers and evaluates branch conditions from them.
// Optional feature macro: INTEGER_FWD_EN -- forwards the in-flight result to
// the read port; when undefined a busy output flags the read hazard instead.
module integer_wb #(
  parameter int WIDTH  = 16,
  parameter int N_REGS = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             en,
  input  logic [3:0]       wr_addr,
  input  logic             wr_flags,
  input  logic             flag_cf,
  input  logic             flag_of,
  input  logic             flag_zf,
  input  logic [1:0]       dout_select,
  input  logic [WIDTH-1:0] dout1,
  input  logic [WIDTH-1:0] dout2,
  input  logic [WIDTH-1:0] dout3,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic [2:0]       cond,
  output logic             cond_true,
  output logic             wb_valid,
  output logic [3:0]       wb_addr
`ifndef INTEGER_FWD_EN
  ,
  output logic             busy
`endif
);

  logic             pend_valid;
  logic [3:0]       pend_addr;
  logic             cf_q;
  logic             of_q;
  logic             zf_q;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] reg_rd;
  logic             wr_in_range;
  logic             rd_in_range;
  logic [WIDTH-1:0] regs [N_REGS];

  // Pending-writeback tracker: remembers whether last cycle issued and where to
  assign wr_in_range = int'(pend_addr) < N_REGS;
  assign rd_in_range = int'(rd_addr) < N_REGS;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pend_valid <= en;
      if (en) pend_addr <= wr_addr;
    end
  end

  // Flag registers: captured only by issues that update flags
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cf_q <= 1'b0;
      of_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (en && wr_flags) begin
      cf_q <= flag_cf;
      of_q <= flag_of;
      zf_q <= flag_zf;
    end
  end

  // Result mux from the integer unit's registered outputs
  always_comb begin
    result = '0;
    case (dout_select)
      2'd1:    result = dout1;
      2'd2:    result = dout2;
      2'd3:    result = dout3;
      default: result = '0;
    endcase
  end

  // A stale selector without a pending issue never produces a writeback
  assign wb_valid = pend_valid & (dout_select != 2'd0);
  assign wb_addr  = pend_addr;

  // Register file: not reset; reset discards the pending write via pend_valid
  always_ff @(posedge CLK) begin
    if (wb_valid && wr_in_range) regs[pend_addr] <= result;
  end

  // Asynchronous read port; out-of-range addresses read zero
  always_comb begin
    reg_rd = '0;
    if (rd_in_range) reg_rd = regs[rd_addr];
  end

`ifdef INTEGER_FWD_EN
  // Read port with bypass of the result being written this cycle
  always_comb begin
    rd_data = reg_rd;
    if (wb_valid && rd_in_range && (rd_addr == pend_addr)) rd_data = result;
  end
`else
  // Read port from the register file only; hazard reported through busy
  always_comb begin
    rd_data = reg_rd;
  end
  assign busy = wb_valid & (rd_addr == pend_addr);
`endif

  // Branch condition evaluation from the flag registers
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = cf_q;
      3'd2:    cond_true = ~cf_q;
      3'd3:    cond_true = zf_q;
      3'd4:    cond_true = ~zf_q;
      3'd5:    cond_true = of_q;
      3'd6:    cond_true = ~of_q;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_integer_wb.sv
// Testbench for integer_wb: directed scenarios followed by random traffic,
// checked against a behavioural register-file/flag model via a scoreboard.
module tb_integer_wb;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        en;
  logic [3:0]  wr_addr;
  logic        wr_flags;
  logic        flag_cf, flag_of, flag_zf;
  logic [1:0]  dout_select;
  logic [15:0] dout1, dout2, dout3;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [2:0]  cond;
  logic        cond_true;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        busy;

  integer_wb #(.WIDTH(16), .N_REGS(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .en(en), .wr_addr(wr_addr),
    .wr_flags(wr_flags), .flag_cf(flag_cf), .flag_of(flag_of),
    .flag_zf(flag_zf), .dout_select(dout_select), .dout1(dout1),
    .dout2(dout2), .dout3(dout3), .rd_addr(rd_addr), .rd_data(rd_data),
    .cond(cond), .cond_true(cond_true), .wb_valid(wb_valid),
    .wb_addr(wb_addr)
`ifndef INTEGER_FWD_EN
    , .busy(busy)
`endif
  );

`ifdef INTEGER_FWD_EN
  assign busy = 1'b0;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [3:0]  wa;
    logic        wf;
    logic        cf, of_, zf;
    logic [1:0]  sel;
    logic [15:0] d1, d2, d3;
    logic [3:0]  ra;
    logic [2:0]  cnd;
  } stim_t;

  typedef struct {
    logic        wbv;
    logic [3:0]  wba;
    logic        rd_chk;
    logic [15:0] rd;
    logic        ct;
    logic        busy;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] wb_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: architectural registers plus one in-flight issue record
  logic [15:0] m_regs [16];
  logic        m_known [16];
  logic        m_pv;
  logic [3:0]  m_pa;
  logic        m_cf, m_of, m_zf;

  function automatic void check(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic cond_eval(logic [2:0] c);
    case (c)
      3'd0: return 1'b1;
      3'd1: return m_cf;
      3'd2: return !m_cf;
      3'd3: return m_zf;
      3'd4: return !m_zf;
      3'd5: return m_of;
      3'd6: return !m_of;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.en = 1'b0; s.wa = '0; s.wf = 1'b0;
    s.cf = 1'b0; s.of_ = 1'b0; s.zf = 1'b0; s.sel = 2'd0;
    s.d1 = '0; s.d2 = '0; s.d3 = '0; s.ra = '0; s.cnd = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n = ($urandom_range(63) != 0);
    s.en  = $urandom_range(3) != 0;
    s.wa  = 4'($urandom);
    s.wf  = 1'($urandom);
    s.cf  = 1'($urandom); s.of_ = 1'($urandom); s.zf = 1'($urandom);
    s.sel = 2'($urandom);
    s.d1  = 16'($urandom); s.d2 = 16'($urandom); s.d3 = 16'($urandom);
    s.ra  = ($urandom_range(1) != 0) ? m_pa : 4'($urandom);
    s.cnd = 3'($urandom);
    return s;
  endfunction

  // Drive one cycle, predict its outputs, then advance the model across the edge
  task automatic cycle(input stim_t s);
    exp_t        e;
    logic [15:0] res;
    logic        hit;
    RESET_N = s.rst_n; en = s.en; wr_addr = s.wa; wr_flags = s.wf;
    flag_cf = s.cf; flag_of = s.of_; flag_zf = s.zf; dout_select = s.sel;
    dout1 = s.d1; dout2 = s.d2; dout3 = s.d3; rd_addr = s.ra; cond = s.cnd;
    if (!s.rst_n) begin
      m_pv = 1'b0; m_cf = 1'b0; m_of = 1'b0; m_zf = 1'b0;
    end
    res = (s.sel == 2'd1) ? s.d1 : (s.sel == 2'd2) ? s.d2 : s.d3;
    e.wbv = m_pv && (s.sel != 2'd0);
    e.wba = m_pa;
    hit   = e.wbv && (s.ra == m_pa);
`ifdef INTEGER_FWD_EN
    e.rd     = hit ? res : m_regs[s.ra];
    e.rd_chk = hit || m_known[s.ra];
    e.busy   = 1'b0;
`else
    e.rd     = m_regs[s.ra];
    e.rd_chk = m_known[s.ra];
    e.busy   = hit;
`endif
    e.ct = cond_eval(s.cnd);
    exp_q.push_back(e);
    if (e.wbv) wb_q.push_back(m_pa);
    @(posedge CLK);
    if (s.rst_n) begin
      if (e.wbv) begin
        m_regs[m_pa] = res;
        m_known[m_pa] = 1'b1;
      end
      m_pv = s.en;
      if (s.en) m_pa = s.wa;
      if (s.en && s.wf) begin
        m_cf = s.cf; m_of = s.of_; m_zf = s.zf;
      end
    end
    #1;
  endtask

  // Monitor: per-cycle outputs against predictions, writebacks against issues
  initial begin
    exp_t       e;
    logic [3:0] a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wb_valid", 16'(wb_valid), 16'(e.wbv));
        check("cond_true", 16'(cond_true), 16'(e.ct));
`ifndef INTEGER_FWD_EN
        check("busy", 16'(busy), 16'(e.busy));
`endif
        if (e.rd_chk) check("rd_data", rd_data, e.rd);
      end
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", 16'(wb_addr), 16'hFFFF);
        end else begin
          a = wb_q.pop_front();
          check("wb_addr", 16'(wb_addr), 16'(a));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_known[i] = 1'b0;
    end
    m_pv = 1'b0; m_pa = '0; m_cf = 1'b0; m_of = 1'b0; m_zf = 1'b0;
    s = idle();
    s.rst_n = 1'b0;
    RESET_N = 1'b0; en = 1'b0; wr_addr = '0; wr_flags = 1'b0;
    flag_cf = 1'b0; flag_of = 1'b0; flag_zf = 1'b0; dout_select = '0;
    dout1 = '0; dout2 = '0; dout3 = '0; rd_addr = '0; cond = '0;
    @(posedge CLK); #1;

    // Reset state: every condition code against cleared flags
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.rst_n = 1'b0; s.cnd = 3'(i); s.sel = 2'd1;
      cycle(s);
    end

    // Fill every register back-to-back so later reads are defined
    for (int i = 0; i <= 16; i++) begin
      s = idle();
      s.en = (i < 16); s.wa = 4'(i);
      s.sel = (i == 0) ? 2'd0 : 2'((i % 3) + 1);
      s.d1 = 16'($urandom); s.d2 = 16'($urandom); s.d3 = 16'($urandom);
      s.ra = 4'(i); s.cnd = 3'(i);
      cycle(s);
    end

    // Issue to r3, result 0x1234, then stale selector with 0xFFFF
    s = idle(); s.en = 1'b1; s.wa = 4'd3; cycle(s);
    s = idle(); s.sel = 2'd1; s.d1 = 16'h1234; s.ra = 4'd3; cycle(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.sel = 2'd1; s.d1 = 16'hFFFF; s.ra = 4'd3; cycle(s);
    end

    // Flag capture and hold
    s = idle(); s.en = 1'b1; s.wa = 4'd9; s.wf = 1'b1; s.zf = 1'b1; s.cnd = 3'd3;
    cycle(s);
    s = idle(); s.cnd = 3'd3; cycle(s);
    s = idle(); s.cnd = 3'd2; cycle(s);
    s = idle(); s.en = 1'b1; s.wa = 4'd9; s.wf = 1'b0; s.cf = 1'b1; s.cnd = 3'd3;
    cycle(s);
    s = idle(); s.cnd = 3'd3; s.sel = 2'd2; s.d2 = 16'h0099; cycle(s);
    s = idle(); s.cnd = 3'd4; cycle(s);

    // Read of r5 during its own writeback of 0x00AA
    s = idle(); s.en = 1'b1; s.wa = 4'd5; cycle(s);
    s = idle(); s.sel = 2'd1; s.d1 = 16'h00AA; s.ra = 4'd5; cycle(s);
    s = idle(); s.ra = 4'd5; cycle(s);

    // Three back-to-back writes to r1; last one wins
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.en = (i < 3); s.wa = 4'd1;
      s.sel = (i == 0) ? 2'd0 : 2'd3; s.d3 = 16'(i); s.ra = 4'd1;
      cycle(s);
    end
    s = idle(); s.ra = 4'd1; cycle(s);

    // Reset during the writeback cycle of r7 discards the write
    s = idle(); s.en = 1'b1; s.wa = 4'd7; s.wf = 1'b1; s.cf = 1'b1;
    s.of_ = 1'b1; s.zf = 1'b1; cycle(s);
    s = idle(); s.rst_n = 1'b0; s.sel = 2'd1; s.d1 = 16'hBEEF; s.ra = 4'd7;
    s.cnd = 3'd2; cycle(s);
    s = idle(); s.ra = 4'd7; s.cnd = 3'd6; cycle(s);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      s = rnd();
      cycle(s);
    end
    s = idle(); cycle(s);
    s = idle(); cycle(s);
    @(negedge CLK);
    check("wb_queue_left", 16'(wb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_wb.md
INTEGER_WB -- requirements
Module: integer_wb

Interface
REQ-001 Parameter WIDTH, default 16, sets the data width of results and registers.
REQ-002 Parameter N_REGS, default 16, sets the number of integer registers; the address width is 4 bits.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  issue strobe, the same enable given to the integer unit in the issue cycle.
REQ-006 wr_addr  in  4  destination register of the issued instruction, sampled with en.
REQ-007 wr_flags  in  1  issued instruction updates flags, sampled with en.
REQ-008 flag_cf, flag_of, flag_zf  in  1 each  combinational flags from the integer unit, valid in the issue cycle.
REQ-009 dout_select  in  2  integer unit result selector, valid the cycle after issue: 0 none, 1 dout1, 2 dout2, 3 dout3.
REQ-010 dout1, dout2, dout3  in  WIDTH each  integer unit registered results.
REQ-011 rd_addr  in  4  read port address.
REQ-012 rd_data  out  WIDTH  read port data.
REQ-013 cond  in  3  branch condition code.
REQ-014 cond_true  out  1  evaluated condition.
REQ-015 wb_valid, wb_addr  out  1, 4  writeback occurring this cycle, and its target register.
REQ-016 busy  out  1  read hazard stall; exists only without INTEGER_FWD_EN.

Function
REQ-017 Issue edge T (en=1) SHALL latch pend_valid<=1, pend_addr<=wr_addr; if en=0, pend_valid<=0.
REQ-018 In cycle T+1, result = dout1/dout2/dout3 per dout_select; wb_valid = pend_valid & (dout_select!=0); wb_addr = pend_addr.
REQ-019 When wb_valid=1, the edge ending T+1 SHALL write result to regfile[pend_addr]; issue-to-visible latency is 2 edges.
REQ-020 A stale dout_select held by the integer unit while pend_valid=0 SHALL NOT cause a write.
REQ-021 Back-to-back issues SHALL pipeline with one writeback per cycle, including to the same address; the last write wins.
REQ-022 An edge with en=1 and wr_flags=1 SHALL latch {CF,OF,ZF}<=flag inputs; otherwise the flags hold.
REQ-023 cond_true SHALL be combinational from the flag registers: 0 always, 1 CF, 2 !CF, 3 ZF, 4 !ZF, 5 OF, 6 !OF, 7 never.
REQ-024 rd_data SHALL be an asynchronous read of regfile[rd_addr], overridden by REQ-027 when the macro is defined.
REQ-025 Addresses >= N_REGS SHALL be ignored on write and SHALL read 0.

Reset
REQ-026 RESET_N=0 SHALL immediately clear pend_valid, CF/OF/ZF, wb_valid, and busy, and SHALL discard any pending writeback; regfile contents are unaffected, and cond_true follows the zeroed flags (1 for cond 0, 2, 4, 6).

Configuration
REQ-027 With INTEGER_FWD_EN defined: when wb_valid=1 and rd_addr==pend_addr, rd_data SHALL equal the in-flight result; busy is absent.
REQ-028 Without INTEGER_FWD_EN: rd_data SHALL come from regfile only, and busy = wb_valid & (rd_addr==pend_addr).

Verification
REQ-029 Issue en=1, wr_addr=3, next cycle dout_select=1, dout1=0x1234 -> regfile[3]=0x1234 after 2 edges; wb_valid=1, wb_addr=3 in T+1.
REQ-030 After REQ-029, en=0 for 3 cycles with dout_select held at 1 and dout1 changed to 0xFFFF -> regfile[3] stays 0x1234, wb_valid=0.
REQ-031 Issue with wr_flags=1, flag_zf=1, flag_cf=0 -> cond=3 gives 1 and cond=2 gives 1 from T+1; a later issue with wr_flags=0, zf=0 -> ZF stays 1.
REQ-032 In T+1 of a write of 0x00AA to r5 with rd_addr=5 -> rd_data=0x00AA (FWD_EN); without the macro, busy=1 and rd_data is the old value.
REQ-033 Issue to r7, then RESET_N=0 during T+1 -> r7 unchanged, flags 0, wb_valid 0.
REQ-034 Three consecutive issues to r1 with results 1, 2, 3 -> r1=3 and three wb_valid pulses.
